// File: rtl/rv32imf_apu_arbiter.sv
// ---------------------------------------------------------------------------
// rv32imf_apu_arbiter
//
// Lets NUM_REQ cores share one APU/FPU. Requests are picked round-robin. The
// winner's operands, op and flags go to the FPU. The winner's index is recorded
// in an in-order tag FIFO, so each FPU result can be returned to the core that
// issued it.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   req_req_i/req_gnt_o   per-core request / zero-latency grant
//   req_operands_i        NUM_REQ x NARGS x 32 operands, core r in slice r
//   req_op_i, req_flags_i per-core op / downstream flags
//   req_rvalid_o          one-hot result valid
//   req_rdata_o/rflags_o  result data/flags, broadcast to all cores
//   apu_*                 shared FPU side (req/gnt, operands, op, flags, result)
//   busy_o                work in flight or being requested (FPU clock gate)
//   err_o                 sticky: a result arrived with no outstanding tag
// ---------------------------------------------------------------------------
module rv32imf_apu_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int NARGS           = 3,
  parameter int WOP             = 6,
  parameter int NDSFLAGS        = 15,
  parameter int NUSFLAGS        = 5,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_REQ-1:0]          req_req_i,
  output logic [NUM_REQ-1:0]          req_gnt_o,
  input  logic [NUM_REQ*NARGS*32-1:0] req_operands_i,
  input  logic [NUM_REQ*WOP-1:0]      req_op_i,
  input  logic [NUM_REQ*NDSFLAGS-1:0] req_flags_i,
  output logic [NUM_REQ-1:0]          req_rvalid_o,
  output logic [31:0]                 req_rdata_o,
  output logic [NUSFLAGS-1:0]         req_rflags_o,
  output logic                        apu_req_o,
  input  logic                        apu_gnt_i,
  output logic [NARGS*32-1:0]         apu_operands_o,
  output logic [WOP-1:0]              apu_op_o,
  output logic [NDSFLAGS-1:0]         apu_flags_o,
  input  logic                        apu_rvalid_i,
  input  logic [31:0]                 apu_rdata_i,
  input  logic [NUSFLAGS-1:0]         apu_rflags_i,
  output logic                        busy_o,
  output logic                        err_o
);

  localparam int SW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OPW = NARGS * 32;
  localparam logic [PW:0]   FULL_COUNT = (PW+1)'(MAX_OUTSTANDING);
  localparam logic [SW-1:0] LAST_REQ   = SW'(NUM_REQ - 1);

  logic [SW-1:0] rr_ptr_reg;
  logic [SW-1:0] rr_ptr_next;
  logic [SW-1:0] sel;
  logic          any_req;
  logic          live;
  logic          full;
  logic          empty;
  logic          apu_req_int;
  logic          push;
  logic          pop;
  logic          orphan;
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW:0]   count_reg;
  logic [PW:0]   count_next;
  logic          err_reg;
  logic [SW-1:0] head_tag;

  // Small tag store. The head must be visible in the result cycle, so it is
  // read combinationally.
  logic [SW-1:0] tag_mem [MAX_OUTSTANDING];

  // Every combinational handshake output is forced low while reset is held.
  assign live    = ~rst_i;
  assign any_req = |req_req_i;
  assign full    = (count_reg == FULL_COUNT);
  assign empty   = (count_reg == '0);

  // Round-robin scan that starts at rr_ptr and wraps modulo NUM_REQ.
  always_comb begin
    int  idx;
    logic found;
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_req_i[idx]) begin
        sel   = idx[SW-1:0];
        found = 1'b1;
      end
    end
  end

  assign rr_ptr_next = (sel == LAST_REQ) ? '0 : sel + 1'b1;

  // A full FIFO blocks new requests even if a pop happens in the same cycle.
  // There is no bypass, which keeps the full flag off the rvalid path.
  assign apu_req_int = any_req & ~full;
  assign push        = apu_req_int & apu_gnt_i & live;
  assign pop         = apu_rvalid_i & ~empty & live;
  assign orphan      = apu_rvalid_i & empty & live;
  assign head_tag    = tag_mem[rd_ptr_reg];

  assign apu_req_o      = apu_req_int & live;
  assign apu_operands_o = any_req ? req_operands_i[sel*OPW +: OPW]           : '0;
  assign apu_op_o       = any_req ? req_op_i[sel*WOP +: WOP]                 : '0;
  assign apu_flags_o    = any_req ? req_flags_i[sel*NDSFLAGS +: NDSFLAGS]    : '0;

  assign req_rdata_o  = apu_rdata_i;
  assign req_rflags_o = apu_rflags_i;
  assign busy_o       = ((count_reg != '0) | apu_req_int) & live;
  assign err_o        = err_reg;

  // One-hot grant and result-valid decode for each requester.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_gnt_o[gi]    = push & (sel == SW'(gi));
      assign req_rvalid_o[gi] = pop  & (head_tag == SW'(gi));
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      err_reg    <= 1'b0;
    end else begin
      if (push) begin
        rr_ptr_reg <= rr_ptr_next;
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      if (orphan) err_reg <= 1'b1;
    end
  end

  // Tag storage holds no state of its own. The pointers define its contents,
  // so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (push) tag_mem[wr_ptr_reg] <= sel;
  end

endmodule

// File: tb/tb_rv32imf_apu_arbiter.sv
module tb_rv32imf_apu_arbiter;
  localparam int NUM_REQ = 2;
  localparam int NARGS = 3;
  localparam int WOP = 6;
  localparam int NDSFLAGS = 15;
  localparam int NUSFLAGS = 5;
  localparam int MAX_OUTSTANDING = 4;

  logic                        clk_i = 1'b0;
  logic                        rst_i;
  logic [NUM_REQ-1:0]          req_req_i;
  logic [NUM_REQ-1:0]          req_gnt_o;
  logic [NUM_REQ*NARGS*32-1:0] req_operands_i;
  logic [NUM_REQ*WOP-1:0]      req_op_i;
  logic [NUM_REQ*NDSFLAGS-1:0] req_flags_i;
  logic [NUM_REQ-1:0]          req_rvalid_o;
  logic [31:0]                 req_rdata_o;
  logic [NUSFLAGS-1:0]         req_rflags_o;
  logic                        apu_req_o;
  logic                        apu_gnt_i;
  logic [NARGS*32-1:0]         apu_operands_o;
  logic [WOP-1:0]              apu_op_o;
  logic [NDSFLAGS-1:0]         apu_flags_o;
  logic                        apu_rvalid_i;
  logic [31:0]                 apu_rdata_i;
  logic [NUSFLAGS-1:0]         apu_rflags_i;
  logic                        busy_o;
  logic                        err_o;

  int checks = 0;
  int errors = 0;

  localparam logic [95:0] OPS0 = {32'h0000_0003, 32'h0000_0002, 32'h0000_0001};
  localparam logic [95:0] OPS1 = {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001};

  rv32imf_apu_arbiter #(
    .NUM_REQ(NUM_REQ), .NARGS(NARGS), .WOP(WOP), .NDSFLAGS(NDSFLAGS),
    .NUSFLAGS(NUSFLAGS), .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_req_i(req_req_i), .req_gnt_o(req_gnt_o),
    .req_operands_i(req_operands_i), .req_op_i(req_op_i), .req_flags_i(req_flags_i),
    .req_rvalid_o(req_rvalid_o), .req_rdata_o(req_rdata_o), .req_rflags_o(req_rflags_o),
    .apu_req_o(apu_req_o), .apu_gnt_i(apu_gnt_i),
    .apu_operands_o(apu_operands_o), .apu_op_o(apu_op_o), .apu_flags_o(apu_flags_o),
    .apu_rvalid_i(apu_rvalid_i), .apu_rdata_i(apu_rdata_i), .apu_rflags_i(apu_rflags_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge. New inputs are driven
  // there, and checks follow #1 later.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    req_req_i = '0; apu_gnt_i = 1'b0; apu_rvalid_i = 1'b0;
    step();
    step();
    rst_i = 1'b0;
  endtask

  initial begin
    req_operands_i = {OPS1, OPS0};
    req_op_i       = {6'd9, 6'd5};
    req_flags_i    = {15'h1234, 15'h0011};
    apu_rdata_i    = 32'h0;
    apu_rflags_i   = 5'h0;

    // Reset state. A pending request must still be masked during reset.
    do_reset();
    rst_i = 1'b1; req_req_i = 2'b11; apu_gnt_i = 1'b1; apu_rvalid_i = 1'b1;
    settle();
    check("rst_gnt", 96'(req_gnt_o), 96'h0);
    check("rst_apu_req", 96'(apu_req_o), 96'h0);
    check("rst_rvalid", 96'(req_rvalid_o), 96'h0);
    check("rst_busy", 96'(busy_o), 96'h0);
    check("rst_err", 96'(err_o), 96'h0);
    do_reset();

    // Single requester. Issue, then the result arrives three cycles later.
    step();
    req_req_i = 2'b01; apu_gnt_i = 1'b1;
    settle();
    $display("txn single issue gnt=%b op=%0d", req_gnt_o, apu_op_o);
    check("single_gnt", 96'(req_gnt_o), 96'b01);
    check("single_op", 96'(apu_op_o), 96'd5);
    check("single_operands", apu_operands_o, OPS0);
    check("single_flags", 96'(apu_flags_o), 96'h0011);
    step();
    req_req_i = 2'b00; apu_gnt_i = 1'b0;
    settle();
    check("single_busy_wait", 96'(busy_o), 96'h1);
    check("single_noreq_ops", apu_operands_o, 96'h0);
    step();
    step();
    apu_rvalid_i = 1'b1; apu_rdata_i = 32'h3F80_0000; apu_rflags_i = 5'h3;
    settle();
    $display("txn single result rvalid=%b rdata=%h", req_rvalid_o, req_rdata_o);
    check("single_rvalid", 96'(req_rvalid_o), 96'b01);
    check("single_rdata", 96'(req_rdata_o), 96'h3F80_0000);
    check("single_rflags", 96'(req_rflags_o), 96'h3);
    step();
    apu_rvalid_i = 1'b0;
    settle();
    check("single_busy_idle", 96'(busy_o), 96'h0);

    // Round-robin. Four back-to-back grants fill the FIFO.
    do_reset();
    step();
    req_req_i = 2'b11; apu_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      $display("txn rr issue %0d gnt=%b op=%0d", i, req_gnt_o, apu_op_o);
      check("rr_gnt", 96'(req_gnt_o), (i % 2 == 0) ? 96'b01 : 96'b10);
      check("rr_op", 96'(apu_op_o), (i % 2 == 0) ? 96'd5 : 96'd9);
      step();
    end
    // Full: no request is issued, even while the FPU grants.
    settle();
    check("full_apu_req", 96'(apu_req_o), 96'h0);
    check("full_gnt", 96'(req_gnt_o), 96'h0);
    check("full_busy", 96'(busy_o), 96'h1);
    step();
    // A pop in the same cycle does not reopen the FIFO.
    apu_rvalid_i = 1'b1; apu_rdata_i = 32'h0000_00A0;
    settle();
    check("full_pop_apu_req", 96'(apu_req_o), 96'h0);
    check("full_pop_rvalid", 96'(req_rvalid_o), 96'b01);
    step();
    // Next cycle: count is 3, so request 0 is granted again (rr_ptr back at 0).
    apu_rvalid_i = 1'b0;
    settle();
    check("refill_apu_req", 96'(apu_req_o), 96'h1);
    check("refill_gnt", 96'(req_gnt_o), 96'b01);
    step();
    req_req_i = 2'b00; apu_gnt_i = 1'b0;
    // Drain. The order is 1,0,1 and then the wrapped entry 0.
    for (int i = 0; i < 4; i++) begin
      apu_rvalid_i = 1'b1; apu_rdata_i = 32'h100 + 32'(i);
      settle();
      $display("txn rr result %0d rvalid=%b rdata=%h", i, req_rvalid_o, req_rdata_o);
      check("rr_rvalid", 96'(req_rvalid_o), (i % 2 == 0) ? 96'b10 : 96'b01);
      step();
    end
    apu_rvalid_i = 1'b0;
    settle();
    check("rr_busy_idle", 96'(busy_o), 96'h0);
    check("rr_err", 96'(err_o), 96'h0);

    // FPU stall. After one grant to requester 0, rr_ptr is 1 and must hold.
    do_reset();
    step();
    req_req_i = 2'b01; apu_gnt_i = 1'b1;
    settle();
    check("stall_pre_gnt", 96'(req_gnt_o), 96'b01);
    step();
    req_req_i = 2'b11; apu_gnt_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      $display("txn stall %0d gnt=%b op=%0d", i, req_gnt_o, apu_op_o);
      check("stall_gnt", 96'(req_gnt_o), 96'h0);
      check("stall_ops", apu_operands_o, OPS1);
      step();
    end
    apu_gnt_i = 1'b1;
    settle();
    check("stall_release_gnt", 96'(req_gnt_o), 96'b10);
    check("stall_release_flags", 96'(apu_flags_o), 96'h1234);
    step();
    // Count is 2. Push (grant 0) and pop (oldest entry, tag 0) in one cycle.
    apu_rvalid_i = 1'b1; apu_rdata_i = 32'h0000_0BEE;
    settle();
    $display("txn pushpop gnt=%b rvalid=%b", req_gnt_o, req_rvalid_o);
    check("pp_gnt", 96'(req_gnt_o), 96'b01);
    check("pp_rvalid", 96'(req_rvalid_o), 96'b01);
    step();
    req_req_i = 2'b00; apu_gnt_i = 1'b0;
    // Two entries are left (1 then 0). A third result is an orphan.
    settle();
    check("pp_pop1", 96'(req_rvalid_o), 96'b10);
    step();
    settle();
    check("pp_pop2", 96'(req_rvalid_o), 96'b01);
    check("pp_err_clean", 96'(err_o), 96'h0);
    step();
    settle();
    check("orphan_rvalid", 96'(req_rvalid_o), 96'h0);
    step();
    apu_rvalid_i = 1'b0;
    settle();
    check("orphan_err", 96'(err_o), 96'h1);

    // Protocol error right after reset, with an empty FIFO.
    do_reset();
    settle();
    check("err_cleared", 96'(err_o), 96'h0);
    apu_rvalid_i = 1'b1;
    settle();
    $display("txn protocol-error rvalid=%b", req_rvalid_o);
    check("err_rvalid", 96'(req_rvalid_o), 96'h0);
    check("err_same_cycle", 96'(err_o), 96'h0);
    step();
    apu_rvalid_i = 1'b0;
    settle();
    check("err_set", 96'(err_o), 96'h1);
    step();
    step();
    settle();
    check("err_sticky", 96'(err_o), 96'h1);
    do_reset();
    settle();
    check("err_reset", 96'(err_o), 96'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
